// File: rtl/sram_controller_if.sv
// CPU-side handshake bundle for the SRAM controller: MEM-stage request in, load result and ready out.
interface sram_controller_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              ready;

    modport master (output rd_en, wr_en, address, write_data, input read_data, ready);
    modport slave  (input rd_en, wr_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_controller.sv
// 32-bit load/store to 16-bit async SRAM as two timed half-accesses (LO then HI).
// Optional one-entry read buffer enabled by defining SRAM_READ_BUFFER_EN.
module sram_controller #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned MEM_BASE      = 1024
) (
    input  logic              clk,
    input  logic              rst,
    sram_controller_if.slave  bus,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [17:0]       SRAM_ADDR,
    output logic              SRAM_WE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);
    localparam int unsigned IDX_W = 17;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    typedef struct packed {
        logic             write;
        logic [IDX_W-1:0] word_idx;
        logic [31:0]      wdata;
    } req_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    req_t             req_q;
    logic [31:0]      rdata_q;
    logic [IDX_W-1:0] word_idx_c;
    logic             last_c;
    logic             req_c;
    logic             hit_c;
    logic             start_c;
    logic             dq_oe;
    logic [15:0]      dq_out;

    assign word_idx_c = IDX_W'((bus.address - MEM_BASE) >> 2);
    assign last_c     = (cnt == CNT_W'(ACCESS_CYCLES - 1));
    assign req_c      = bus.rd_en | bus.wr_en;
    assign start_c    = (state == IDLE) && req_c && !hit_c;

`ifdef SRAM_READ_BUFFER_EN
    logic             buf_valid;
    logic [IDX_W-1:0] buf_idx;
    logic [31:0]      buf_data;

    assign hit_c = buf_valid && bus.rd_en && !bus.wr_en && (buf_idx == word_idx_c);

    // Fill on completed reads; keep a matching entry coherent with writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_idx   <= '0;
            buf_data  <= '0;
        end else if (state == DONE) begin
            if (!req_q.write) begin
                buf_valid <= 1'b1;
                buf_idx   <= req_q.word_idx;
                buf_data  <= rdata_q;
            end else if (buf_valid && (buf_idx == req_q.word_idx)) begin
                buf_data  <= req_q.wdata;
            end
        end
    end
`else
    assign hit_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and half-access cycle counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (start_c) begin
                    state_nxt = LO;
                    cnt_nxt   = '0;
                end
            end
            LO: begin
                if (last_c) begin
                    state_nxt = HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            HI: begin
                if (last_c) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and read capture on the last cycle of each half
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (start_c) begin
                req_q.write    <= bus.wr_en;
                req_q.word_idx <= word_idx_c;
                req_q.wdata    <= bus.write_data;
            end
            if ((state == LO) && last_c && !req_q.write) rdata_q[15:0]  <= SRAM_DQ;
            if ((state == HI) && last_c && !req_q.write) rdata_q[31:16] <= SRAM_DQ;
        end
    end

    // Outputs decoded from state; bus is released outside LO/HI
    always_comb begin
        bus.ready     = 1'b0;
        bus.read_data = rdata_q;
        SRAM_ADDR     = '0;
        SRAM_WE_N     = 1'b1;
        dq_oe         = 1'b0;
        dq_out        = '0;
        unique case (state)
            IDLE: begin
                bus.ready = !req_c || hit_c;
`ifdef SRAM_READ_BUFFER_EN
                if (hit_c) bus.read_data = buf_data;
`endif
            end
            LO: begin
                SRAM_ADDR = {req_q.word_idx, 1'b0};
                SRAM_WE_N = !req_q.write;
                dq_oe     = req_q.write;
                dq_out    = req_q.wdata[15:0];
            end
            HI: begin
                SRAM_ADDR = {req_q.word_idx, 1'b1};
                SRAM_WE_N = !req_q.write;
                dq_oe     = req_q.write;
                dq_out    = req_q.wdata[31:16];
            end
            DONE: bus.ready = 1'b1;
            default: bus.ready = 1'b0;
        endcase
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: SRAM halfword writes and load results checked against queues.
module tb_sram_controller;
    localparam int unsigned AC  = 2;
    localparam int unsigned LAT = 2 * AC + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sram_controller_if bus ();
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, ce_n, oe_n, ub_n, lb_n;

    sram_controller #(.ACCESS_CYCLES(AC), .MEM_BASE(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (we_n),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n)
    );

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Asynchronous SRAM model: drives the bus whenever not being written.
    logic [15:0] sram_mem [0:255];
    assign sram_dq = we_n ? sram_mem[sram_addr[7:0]] : 16'bz;

    typedef struct packed {
        logic [17:0] a;
        logic [15:0] d;
    } wev_t;

    wev_t        wr_q [$];
    logic [31:0] rd_q [$];
    logic [31:0] model [logic [16:0]];
    logic [17:0] prev_addr = '0;
    logic        prev_we_n = 1'b1;

`ifdef SRAM_READ_BUFFER_EN
    bit          bvalid = 1'b0;
    logic [16:0] bidx   = '0;
`endif

    // Each new write strobe/address pair is one halfword write event.
    always @(negedge clk) begin
        wev_t e;
        if (!we_n) begin
            sram_mem[sram_addr[7:0]] <= sram_dq;
            if (prev_we_n || (sram_addr != prev_addr)) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", {14'b0, sram_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", {14'b0, sram_addr}, {14'b0, e.a});
                    chk("wr_data", {16'b0, sram_dq}, {16'b0, e.d});
                end
            end
        end
        prev_we_n <= we_n;
        prev_addr <= sram_addr;
    end

    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input bit hold);
        logic [16:0] idx;
        bit          hit;
        int          lat;
        idx = 17'((addr - 32'd1024) >> 2);
        hit = 1'b0;
`ifdef SRAM_READ_BUFFER_EN
        hit = rd && !wr && bvalid && (bidx == idx);
`endif
        @(negedge clk);
        bus.rd_en      = rd;
        bus.wr_en      = wr;
        bus.address    = addr;
        bus.write_data = data;
        if (wr) begin
            wr_q.push_back('{a: {idx, 1'b0}, d: data[15:0]});
            wr_q.push_back('{a: {idx, 1'b1}, d: data[31:16]});
            model[idx] = data;
        end else begin
            rd_q.push_back(model.exists(idx) ? model[idx] : 32'h0);
        end
        #1;
        if (hit) begin
            chk("hit_ready", {31'b0, bus.ready}, 32'd1);
            chk("hit_data", bus.read_data, rd_q.pop_front());
            @(posedge clk);
            @(negedge clk);
            chk("hit_no_sram", {13'b0, we_n, sram_addr}, {13'b0, 1'b1, 18'h0});
        end else begin
            chk("req_ready", {31'b0, bus.ready}, 32'd0);
            lat = 0;
            do begin
                @(posedge clk);
                lat++;
                #1;
                if (lat == 1) begin
                    bus.address    = ~addr;
                    bus.write_data = ~data;
                end
                @(negedge clk);
            end while (!bus.ready && lat < 20);
            chk("latency", 32'(lat), 32'(LAT));
            if (!wr) chk("rd_data", bus.read_data, rd_q.pop_front());
`ifdef SRAM_READ_BUFFER_EN
            if (!wr) begin
                bvalid = 1'b1;
                bidx   = idx;
            end
`endif
            if (hold) begin
                @(negedge clk);
                chk("done_no_restart", {30'b0, we_n, bus.ready}, {30'b0, 1'b1, 1'b0});
            end
        end
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, bus.ready}, 32'd1);
        chk("rst_we_n", {31'b0, we_n}, 32'd1);
        chk("rst_rdata", bus.read_data, 32'h0);
        chk("rst_addr", {14'b0, sram_addr}, 32'h0);
        chk("tied_pins", {28'b0, ce_n, oe_n, ub_n, lb_n}, 32'h0);
        rst = 1'b1;

        access(1'b0, 1'b1, 32'd1024, 32'h1234_ABCD, 1'b0);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
        access(1'b0, 1'b1, 32'd1030, 32'hDEAD_BEEF, 1'b0);
        access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        access(1'b1, 1'b1, 32'd1024, 32'h0000_0005, 1'b0);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);

        // Repeat read (buffer hit when enabled), then write-through and re-read
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
        access(1'b0, 1'b1, 32'd1024, 32'h0000_0007, 1'b0);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);

        // Request held through DONE must not restart an access
        access(1'b0, 1'b1, 32'd1224, 32'hCAFE_0001, 1'b1);
        access(1'b1, 1'b0, 32'd1224, 32'h0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            a = 32'd1024 + 32'(i * 4 + 12) * 32'd4 + 32'($urandom_range(0, 3));
            d = $urandom;
            access(1'b0, 1'b1, a, d, 1'b0);
            access(1'b1, 1'b0, a, 32'h0, 1'b0);
        end

        // Reset in the second LO cycle of a write aborts it
        @(negedge clk);
        wr_q.push_back('{a: {17'd40, 1'b0}, d: 16'hF00D});
        bus.wr_en      = 1'b1;
        bus.address    = 32'd1024 + 32'd160;
        bus.write_data = 32'h0BAD_F00D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        bus.wr_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_we_n", {31'b0, we_n}, 32'd1);
        chk("abort_ready", {31'b0, bus.ready}, 32'd1);
        chk("abort_rdata", bus.read_data, 32'h0);
        chk("abort_addr", {14'b0, sram_addr}, 32'h0);
        rst = 1'b1;
`ifdef SRAM_READ_BUFFER_EN
        bvalid = 1'b0;
`endif
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);

        repeat (2) @(negedge clk);
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The block SHALL take parameter ACCESS_CYCLES, default 2: clock cycles per 16-bit SRAM half-access, legal range 1-7.
REQ-002 The block SHALL take parameter MEM_BASE, default 1024: byte address that maps to SRAM halfword 0.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port rd_en, input, 1 bit: MEM-stage load request.
REQ-006 Port wr_en, input, 1 bit: MEM-stage store request.
REQ-007 Port address, input, 32 bits: byte address, taken from the ALU result.
REQ-008 Port write_data, input, 32 bits: store data, taken from Val_Rm.
REQ-009 Port read_data, output, 32 bits: load result.
REQ-010 Port ready, output, 1 bit: 0 means access in progress; the pipeline freeze is ~ready.
REQ-011 Port SRAM_DQ, inout, 16 bits: external data bus.
REQ-012 Port SRAM_ADDR, output, 18 bits: external halfword address.
REQ-013 Port SRAM_WE_N, output, 1 bit: external write strobe, active-low.
REQ-014 Ports SRAM_CE_N, SRAM_OE_N, SRAM_UB_N and SRAM_LB_N, outputs, 1 bit each: tied 0.

Function
REQ-015 Word index SHALL be (address - MEM_BASE)[18:2]; address[1:0] SHALL be ignored.
REQ-016 SRAM_ADDR SHALL be {word_index[16:0], half}, where half=0 selects bits [15:0] and half=1 selects bits [31:16].
REQ-017 The FSM SHALL have states IDLE, LO, HI and DONE.
REQ-018 IDLE: with rd_en|wr_en=1, the block SHALL latch address, write_data and op, then go to LO; if both are set, op SHALL be write.
REQ-019 ready SHALL be a combinational output: 1 in IDLE with no request; 0 in IDLE with a request; 0 in LO and HI; 1 in DONE.
REQ-020 LO SHALL last exactly ACCESS_CYCLES cycles with half=0, using a 3-bit cycle counter, then go to HI.
REQ-021 HI SHALL behave the same as LO with half=1, then go to DONE.
REQ-022 Writes: SRAM_DQ SHALL drive the selected write_data half and SRAM_WE_N=0 for every cycle of LO and HI.
REQ-023 Reads: SRAM_DQ SHALL be high-Z and SRAM_WE_N=1; SRAM_DQ SHALL be sampled on the last cycle of LO into read_data[15:0] and of HI into read_data[31:16].
REQ-024 DONE SHALL last 1 cycle, with read_data stable and valid, then go to IDLE; the still-asserted request SHALL NOT start a second access in that cycle.
REQ-025 A request arriving in IDLE after DONE SHALL start a new access.
REQ-026 Request latency from the first IDLE request cycle to ready=1 SHALL be 2*ACCESS_CYCLES+1 cycles.
REQ-027 Outside LO and HI, SRAM_DQ SHALL be high-Z and SRAM_WE_N=1.
REQ-028 read_data SHALL hold its last value until the next read capture.
REQ-029 Changes on inputs after latching SHALL NOT affect the access in progress.

Reset
REQ-030 With rst=0 at a clock edge, the FSM SHALL enter IDLE with counter=0, read_data=0, SRAM_WE_N=1, SRAM_DQ high-Z and SRAM_ADDR=0.
REQ-031 A reset during LO or HI SHALL abort the access immediately; a partially written word is permitted.

Configuration
REQ-032 Macro SRAM_READ_BUFFER_EN, when defined, SHALL add a one-entry read buffer (valid flag, word index, 32-bit data).
REQ-033 With SRAM_READ_BUFFER_EN: a read in IDLE whose word index matches a valid buffer entry SHALL return the buffered data combinationally, keep ready=1 and start no SRAM access.
REQ-034 With SRAM_READ_BUFFER_EN: a completed read SHALL fill the buffer.
REQ-035 With SRAM_READ_BUFFER_EN: a write whose word index matches the buffer entry SHALL update the buffer data when it reaches DONE.
REQ-036 With SRAM_READ_BUFFER_EN: reset SHALL clear the valid flag.
REQ-037 Without SRAM_READ_BUFFER_EN, every read SHALL perform the full SRAM access and no buffer logic SHALL exist.

Verification (ACCESS_CYCLES=2)
REQ-038 Write 0x1234ABCD to 1024 -> SRAM_ADDR 0 written 0xABCD and SRAM_ADDR 1 written 0x1234; ready=0 for 5 cycles, then 1 for 1 cycle.
REQ-039 Read 1024 after REQ-038 -> read_data=0x1234ABCD in DONE, latency 5.
REQ-040 Write 0xDEADBEEF to 1030 -> SRAM_ADDR 2/3 receive 0xBEEF/0xDEAD, since bits[1:0] are ignored.
REQ-041 rd_en=wr_en=1 to 1024 with data 0x5 -> write performed; a following read returns 0x5.
REQ-042 Reset asserted in the second LO cycle of a write -> next cycle IDLE, SRAM_WE_N=1, DQ high-Z, read_data=0.
REQ-043 SRAM_READ_BUFFER_EN: two reads of 1024 -> first latency 5, second ready stays 1 with no SRAM_ADDR activity; a write of 0x7 to 1024 then a read -> 0x7 returned from the buffer.
